// File: rtl/multdiv_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide scheduler.
// A request transfers when req_valid && req_ready && !flush; resp_valid is a one-cycle write strobe for HI/LO with no back-pressure.
interface multdiv_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        req_ready;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_hi;
    logic [31:0] resp_lo;

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        input  req_ready, busy, resp_valid, resp_hi, resp_lo
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        output req_ready, busy, resp_valid, resp_hi, resp_lo
    );
endinterface

// File: rtl/multdiv_scheduler.sv
// MULT/MULTU/DIV/DIVU scheduler: fixed-latency multiply, 32-cycle restoring divide, HI/LO result strobe.
// Define MULTDIV_DIVZERO_FAST_EN to finish divide-by-zero in one cycle instead of 33.
module multdiv_scheduler #(
    parameter int MUL_LATENCY = 3
) (
    input  logic       clk,
    input  logic       reset,
    multdiv_if.slave   bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, quot_q, rem_q;
    logic [31:0] resp_hi_q, resp_lo_q, resp_hi_d, resp_lo_d;
    logic        load_resp;
    logic        accept;

    function automatic logic [63:0] mul64(input logic is_unsigned, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = is_unsigned ? {32'd0, a} : {{32{a[31]}}, a};
        xb = is_unsigned ? {32'd0, b} : {{32{b[31]}}, b};
        return xa * xb;
    endfunction

    assign accept = bus.req_valid & (state == IDLE) & ~bus.flush;

    // Divider works on magnitudes; signs are reapplied after the final iteration.
    logic        a_neg, b_neg;
    logic [31:0] divisor, a_mag_in;
    logic [32:0] shifted, diff;
    logic        fits;
    logic [31:0] rem_step, quot_step, rem_fix, quot_fix;
    logic [63:0] prod_q, prod_in;

    assign a_neg     = ~op_q[0] & a_q[31];
    assign b_neg     = ~op_q[0] & b_q[31];
    assign divisor   = b_neg ? -b_q : b_q;
    assign a_mag_in  = (~bus.req_op[0] & bus.req_a[31]) ? -bus.req_a : bus.req_a;
    assign shifted   = {rem_q, quot_q[31]};
    assign diff      = shifted - {1'b0, divisor};
    assign fits      = shifted >= {1'b0, divisor};
    assign rem_step  = fits ? diff[31:0] : shifted[31:0];
    assign quot_step = {quot_q[30:0], fits};
    assign quot_fix  = (a_neg ^ b_neg) ? -quot_step : quot_step;
    assign rem_fix   = a_neg ? -rem_step : rem_step;
    assign prod_q    = mul64(op_q[0], a_q, b_q);
    assign prod_in   = mul64(bus.req_op[0], bus.req_a, bus.req_b);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        load_resp = 1'b0;
        resp_hi_d = resp_hi_q;
        resp_lo_d = resp_lo_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_op[1]) begin
                        cnt_d = 6'(MUL_LATENCY - 1);
                        if (MUL_LATENCY == 1) begin
                            state_d   = DONE;
                            load_resp = 1'b1;
                            resp_hi_d = prod_in[63:32];
                            resp_lo_d = prod_in[31:0];
                        end else begin
                            state_d = MUL;
                        end
                    end else begin
                        cnt_d   = 6'd0;
`ifdef MULTDIV_DIVZERO_FAST_EN
                        if (bus.req_b == 32'd0) begin
                            state_d   = DONE;
                            load_resp = 1'b1;
                            resp_hi_d = bus.req_a;
                            resp_lo_d = 32'hFFFF_FFFF;
                        end else begin
                            state_d = DIV;
                        end
`else
                        state_d = DIV;
`endif
                    end
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (cnt <= 6'd1) begin
                    state_d   = DONE;
                    cnt_d     = 6'd0;
                    load_resp = 1'b1;
                    resp_hi_d = prod_q[63:32];
                    resp_lo_d = prod_q[31:0];
                end else begin
                    cnt_d = cnt - 6'd1;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (cnt == 6'd31) begin
                    state_d   = DONE;
                    cnt_d     = 6'd0;
                    load_resp = 1'b1;
                    // Divide-by-zero returns the raw dividend, bypassing sign fixup.
                    resp_hi_d = (b_q == 32'd0) ? a_q : rem_fix;
                    resp_lo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : quot_fix;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            resp_hi_q <= 32'd0;
            resp_lo_q <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load_resp) begin
                resp_hi_q <= resp_hi_d;
                resp_lo_q <= resp_lo_d;
            end
            if (accept) begin
                op_q   <= bus.req_op;
                a_q    <= bus.req_a;
                b_q    <= bus.req_b;
                quot_q <= a_mag_in;
                rem_q  <= 32'd0;
            end else if (state == DIV) begin
                quot_q <= quot_step;
                rem_q  <= rem_step;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state == MUL) || (state == DIV);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_hi    = resp_hi_q;
    assign bus.resp_lo    = resp_lo_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_multdiv_scheduler.sv
// Bench for multdiv_scheduler: directed corner cases plus random ops against an arithmetic model.
module tb_multdiv_scheduler;
    localparam int MUL_LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         total_cnt = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    multdiv_if bus ();

    multdiv_scheduler #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin u = 64'(a) * 64'(b); hi = u[63:32]; lo = u[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    p = sa / sb; lo = p[31:0];
                    p = sa % sb; hi = p[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return MUL_LAT;
`ifdef MULTDIV_DIVZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit flush_in_done);
        logic [31:0] eh, el;
        int lat, n;
        bit seen, busy_ok;
        model(op, a, b, eh, el);
        lat = model_lat(op, b);
        @(negedge clk);
        check({tag, "_idle_valid"}, {63'd0, bus.resp_valid}, 64'd0);
        check({tag, "_held"}, {bus.resp_hi, bus.resp_lo}, {last_hi, last_lo});
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        check({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op = 2'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 60) begin
            @(negedge clk); n++;
            if (bus.resp_valid) seen = 1;
            else if (bus.busy !== 1'b1) busy_ok = 0;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_hilo"}, {bus.resp_hi, bus.resp_lo}, {eh, el});
        check({tag, "_done_ready"}, {62'd0, bus.req_ready, bus.busy}, 64'd0);
        last_hi = eh; last_lo = el;
        if (flush_in_done) begin
            bus.flush = 1'b1; #1;
            check({tag, "_flush_done_valid"}, {63'd0, bus.resp_valid}, 64'd1);
            @(posedge clk); #1;
            bus.flush = 1'b0;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_hi, bus.resp_lo},
              {1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
        reset = 1'b0;

        run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg", 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7", 0);
        run_op(2'd3, 32'd100, 32'd7, "divu_100_7", 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        run_op(2'd3, 32'h1234_5678, 32'd0, "divu_zero", 0);
        run_op(2'd2, 32'h8765_4321, 32'd0, "div_zero_neg", 0);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "div_pos_neg", 0);
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, "mult_flush_done", 1);

        for (int k = 0; k < 16; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", k, rop), 0);
        end

        // Flush a divide at T+10, then a multiply at T+11; no divide result through T+40.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_a = 32'd1000; bus.req_b = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        count_pulses(10, pulses);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("div_flush_pre_pulses", 64'(pulses), 64'd0);
        run_op(2'd0, 32'd6, 32'd7, "mult_after_flush", 0);
        count_pulses(26, pulses);
        check("div_flush_post_pulses", 64'(pulses), 64'd0);

        // Flush coinciding with a request in IDLE drops the request.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_op = 2'd1; bus.req_a = 32'd5; bus.req_b = 32'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("idle_flush_state", {62'd0, bus.req_ready, bus.busy}, 64'd2);
        count_pulses(10, pulses);
        check("idle_flush_pulses", 64'(pulses), 64'd0);

        // Reset during a divide at T+5.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'd3; bus.req_a = 32'd99; bus.req_b = 32'd4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        count_pulses(5, pulses);
        reset = 1'b1;
        @(negedge clk);
        check("midop_reset_outputs",
              {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_hi, bus.resp_lo},
              {1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
        reset = 1'b0;
        last_hi = 32'd0; last_lo = 32'd0;
        count_pulses(40, pulses);
        check("midop_reset_pulses", 64'(pulses), 64'd0);

        run_op(2'd1, 32'd12, 32'd13, "multu_after_reset", 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/multdiv_scheduler.md
MULTDIV_SCHEDULER -- requirements
Module: multdiv_scheduler

Interface
REQ-001 Parameter MUL_LATENCY, default 3, cycles from request acceptance to multiply result; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  EX stage presents a MULT/MULTU/DIV/DIVU operation.
REQ-005 req_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 req_a  input  32  rs operand (multiplicand/dividend).
REQ-007 req_b  input  32  rt operand (multiplier/divisor).
REQ-008 flush  input  1  pipeline flush (exception/ERET); aborts in-flight operation.
REQ-009 req_ready  output  1  high when the scheduler can accept a request this cycle.
REQ-010 busy  output  1  stall to pipeline; high while an accepted operation has not produced its result.
REQ-011 resp_valid  output  1  one-cycle pulse; HI/LO write enable.
REQ-012 resp_hi  output  32  value for HI.
REQ-013 resp_lo  output  32  value for LO.

Function
REQ-014 States: IDLE, MUL, DIV, DONE; req_ready = (state==IDLE); busy = (state==MUL or state==DIV).
REQ-015 Accept = req_valid & req_ready & ~flush; operands and op captured into internal registers at acceptance; later input changes are ignored.
REQ-016 IDLE -> MUL on accepted op 0x/01; IDLE -> DIV on accepted op 1x.
REQ-017 MUL: counter loaded at acceptance; DONE entered so resp_valid is high exactly MUL_LATENCY cycles after the acceptance cycle.
REQ-018 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: radix-2 restoring divider on operand magnitudes, 6-bit iteration counter, exactly 32 iteration cycles; resp_valid in cycle acceptance+33.
REQ-020 lo = quotient, hi = remainder; signed quotient negative iff signs differ, remainder takes sign of dividend.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000, no exception.
REQ-022 Divisor zero: lo = 0xFFFFFFFF, hi = dividend (unsigned and signed alike, no sign fixup).
REQ-023 DONE lasts exactly one cycle with resp_valid=1, then IDLE; resp_hi/resp_lo hold last result until next DONE.
REQ-024 A new request is not accepted in DONE; earliest back-to-back acceptance is the cycle after DONE.
REQ-025 flush in MUL or DIV: next state IDLE, no resp_valid for that operation.
REQ-026 flush in DONE: resp_valid still asserted that cycle (result belongs to an older, committed instruction); state -> IDLE.
REQ-027 flush with req_valid in IDLE: request dropped, state stays IDLE.

Reset
REQ-028 reset forces state IDLE, counters 0, resp_valid 0, busy 0, req_ready 1, resp_hi 0, resp_lo 0.
REQ-029 reset mid-operation discards the operation; no resp_valid is produced; reset has priority over flush and req_valid.

Configuration
REQ-030 Macro MULTDIV_DIVZERO_FAST_EN: when defined, DIV/DIVU with req_b==0 goes IDLE -> DONE directly, resp_valid at acceptance+1, values per REQ-022.
REQ-031 Without MULTDIV_DIVZERO_FAST_EN, divide-by-zero runs the full 32 iterations (resp_valid at acceptance+33) with identical result values.

Verification
REQ-032 MULT a=0xFFFFFFFE (-2), b=0x00000003 accepted cycle T -> resp_valid at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high T+1..T+2.
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T+MUL_LATENCY.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> resp_valid at T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-035 DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 at T+1 with macro, T+33 without.
REQ-036 DIV accepted at T, flush at T+10 -> IDLE at T+11, no resp_valid through T+40; new MULT accepted at T+11 completes normally.
REQ-037 reset asserted at T+5 of a DIV -> all outputs at reset values next cycle, req_ready=1, no resp_valid.
